// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction memory fetch port.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h00000013;
  localparam logic [31:0] FAULT_INSTR_DEF = 32'hfff00893;

  // Bit positions inside the 2-bit fault field.
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef logic [1:0] fault_t;

endpackage

// File: rtl/imem_rsp_fifo2.sv
// Two-entry response FIFO. Entry 0 is always the head; a pop shifts entry 1 down.
// Clear has priority over push/pop. The owner never pops when empty and never
// pushes without a pop when full.
module imem_rsp_fifo2
  import imem_pkg::*;
#(
  parameter int W = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic [1:0]   r_count;

  // Entry storage and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= i_data;
          else                 r_ent1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_data;
          end else begin
            r_ent0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_ent0;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port and a program-loader write port.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// a valid source holds its payload until that edge; ready may depend on the other
// side's valid/ready in the same cycle (rsp_ready feeds req_ready combinationally).
// Every accepted fetch lands in stage s1 for exactly one cycle; it is either popped
// straight from s1 (FIFO empty) or moved into the 2-entry FIFO, so occupancy <= 2.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int                    PC_WIDTH    = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 64,
  parameter logic [DATA_WIDTH-1:0] FAULT_INSTR = DATA_WIDTH'(FAULT_INSTR_DEF),
  parameter string                 INIT_FILE   = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [PC_WIDTH-1:0]      req_pc,
  input  logic                     flush,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_instr,
  output logic [PC_WIDTH-1:0]      rsp_pc,
  output logic [1:0]               rsp_fault,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH):0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = PC_WIDTH - 2;
  localparam int EW = PC_WIDTH + DATA_WIDTH + 2;
  localparam logic [IW-1:0] IDX_DEPTH = IW'(DEPTH);
  localparam logic [AW:0]   LD_DEPTH  = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_s1_valid;
  logic [PC_WIDTH-1:0]   r_s1_pc;
  logic [DATA_WIDTH-1:0] r_s1_instr;
  fault_t                r_s1_fault;
  logic                  r_ld_err;

  logic [IW-1:0]         w_index;
  fault_t                w_fault;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_ld_oob;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic                  w_fifo_empty;
  logic [1:0]            w_fifo_count;
  logic [1:0]            w_occ;
  logic [1:0]            w_occ_after_pop;
  logic [EW-1:0]         w_fifo_head;
  logic [PC_WIDTH-1:0]   w_head_pc;
  logic [DATA_WIDTH-1:0] w_head_instr;
  fault_t                w_head_fault;

  // Power-up image of the array; the array itself is never reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = DATA_WIDTH'(NOP_INSTR);
  end

  assign w_index  = req_pc[PC_WIDTH-1:2];
  assign w_ld_oob = (ld_addr >= LD_DEPTH);

  // Fault decode of the requested PC; both bits may be set together.
  always_comb begin
    w_fault                 = '0;
    w_fault[FAULT_MISALIGN] = |req_pc[1:0];
    w_fault[FAULT_RANGE]    = (w_index >= IDX_DEPTH);
  end

  // Credit logic: a slot freed by a pop this cycle can be reused by this cycle's accept.
  assign w_occ           = {1'b0, r_s1_valid} + w_fifo_count;
  assign w_occ_after_pop = w_occ - {1'b0, w_pop};
  assign req_ready       = !ld_we && rst_n && (w_occ_after_pop < 2'd2);
  assign w_accept        = req_valid && req_ready;
  assign w_pop           = rsp_valid && rsp_ready;

  // s1 leaves every cycle: into the FIFO unless it is the entry being popped.
  assign w_fifo_empty = (w_fifo_count == 2'd0);
  assign w_fifo_push  = r_s1_valid && !(w_pop && w_fifo_empty);
  assign w_fifo_pop   = w_pop && !w_fifo_empty;

  // Loader write; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (ld_we && !w_ld_oob) r_mem[ld_addr[AW-1:0]] <= ld_data;
  end

  // Loader error pulse, one cycle after the bad write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ld_err <= 1'b0;
    else        r_ld_err <= ld_we && w_ld_oob;
  end

  // Stage s1: synchronous read of the accepted fetch; faulting fetches skip the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_pc    <= '0;
      r_s1_instr <= '0;
      r_s1_fault <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_pc    <= req_pc;
      r_s1_fault <= w_fault;
      r_s1_instr <= (|w_fault) ? FAULT_INSTR : r_mem[w_index[AW-1:0]];
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  imem_rsp_fifo2 #(.W(EW)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_clear (flush),
    .i_data  ({r_s1_pc, r_s1_instr, r_s1_fault}),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  assign {w_head_pc, w_head_instr, w_head_fault} = w_fifo_head;

  // Response mux: the FIFO head is older than s1, so it wins when present.
  always_comb begin
    rsp_valid = r_s1_valid;
    rsp_pc    = r_s1_pc;
    rsp_instr = r_s1_instr;
    rsp_fault = r_s1_fault;
    if (!w_fifo_empty) begin
      rsp_valid = 1'b1;
      rsp_pc    = w_head_pc;
      rsp_instr = w_head_instr;
      rsp_fault = w_head_fault;
    end
  end

  assign ld_err = r_ld_err;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or #1 after it for comb paths).
module tb_imem_fetch_port;

  localparam int PC_WIDTH   = 16;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 64;
  localparam int AW         = $clog2(DEPTH);
  localparam int EW         = PC_WIDTH + DATA_WIDTH + 2;
  localparam logic [31:0] FAULT_W = 32'hfff00893;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  req_valid;
  logic                  req_ready;
  logic [PC_WIDTH-1:0]   req_pc;
  logic                  flush;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [PC_WIDTH-1:0]   rsp_pc;
  logic [1:0]            rsp_fault;
  logic                  ld_we;
  logic [AW:0]           ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_err;

  imem_fetch_port #(
    .PC_WIDTH   (PC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_err    (ld_err)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [PC_WIDTH-1:0] pc, input logic [DATA_WIDTH-1:0] instr,
                          input logic [1:0] fault);
    exp_q.push_back({pc, instr, fault});
  endtask

  // Compares the presented response against the oldest expected one.
  task automatic check_rsp(input string tag);
    logic [EW-1:0] e;
    e = '1;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check(tag, 64'({rsp_pc, rsp_instr, rsp_fault}), 64'(e));
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [DATA_WIDTH-1:0] data);
    ld_we   = 1'b1;
    ld_addr = (AW + 1)'(idx);
    ld_data = data;
    tick();
    ld_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
    rsp_ready = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_instr", 64'(rsp_instr), 64'd0);
    check("rst_pc",    64'(rsp_pc),    64'd0);
    check("rst_fault", 64'(rsp_fault), 64'd0);
    check("rst_ld_err", 64'(ld_err),   64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load(0, 32'h00300413);
    load(1, 32'h00100493);
    load(2, 32'h01000913);
    load(5, 32'hff5ff06f);

    // 1: back-to-back fetches, one response per cycle, latency 1
    rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 16'h0000; #1;
    check("t1_idle_valid", 64'(rsp_valid), 64'd0);
    check("t1_ready0", 64'(req_ready), 64'd1);
    push_exp(16'h0000, 32'h00300413, 2'b00); tick();
    check_rsp("t1_rsp0");
    req_pc = 16'h0004; #1;
    check("t1_ready1", 64'(req_ready), 64'd1);
    push_exp(16'h0004, 32'h00100493, 2'b00); tick();
    check_rsp("t1_rsp1");
    req_pc = 16'h0008;
    push_exp(16'h0008, 32'h01000913, 2'b00); tick();
    check_rsp("t1_rsp2");
    req_valid = 1'b0; tick();
    check("t1_drain", 64'(rsp_valid), 64'd0);

    // 2: backpressure, third request held off until the first pop
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 16'h0000;
    push_exp(16'h0000, 32'h00300413, 2'b00); tick();
    req_pc = 16'h0004;
    push_exp(16'h0004, 32'h00100493, 2'b00); tick();
    req_pc = 16'h0008; #1;
    check("t2_full_ready", 64'(req_ready), 64'd0);
    check("t2_head_pc", 64'(rsp_pc), 64'h0000);
    check("t2_head_instr", 64'(rsp_instr), 64'h00300413);
    tick();
    check("t2_stall_ready", 64'(req_ready), 64'd0);
    check("t2_stable_pc", 64'(rsp_pc), 64'h0000);
    check("t2_stable_instr", 64'(rsp_instr), 64'h00300413);
    rsp_ready = 1'b1; #1;
    check("t2_pop_ready", 64'(req_ready), 64'd1);
    check_rsp("t2_rsp0");
    push_exp(16'h0008, 32'h01000913, 2'b00); tick();
    req_valid = 1'b0;
    check_rsp("t2_rsp1"); tick();
    check_rsp("t2_rsp2"); tick();
    check("t2_drain", 64'(rsp_valid), 64'd0);

    // 3: fault decode, including the last in-range word
    req_valid = 1'b1; req_pc = 16'h0006;
    push_exp(16'h0006, FAULT_W, 2'b01); tick();
    check_rsp("t3_misalign");
    req_pc = 16'h0100;
    push_exp(16'h0100, FAULT_W, 2'b10); tick();
    check_rsp("t3_range");
    req_pc = 16'h0102;
    push_exp(16'h0102, FAULT_W, 2'b11); tick();
    check_rsp("t3_both");
    req_pc = 16'h00fc;
    push_exp(16'h00fc, 32'h00000013, 2'b00); tick();
    check_rsp("t3_last_word");
    req_valid = 1'b0; tick();
    check("t3_drain", 64'(rsp_valid), 64'd0);

    // 4: flush with a pop and a new accept in the same cycle
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 16'h0000;
    push_exp(16'h0000, 32'h00300413, 2'b00); tick();
    req_pc = 16'h0004; tick();
    flush = 1'b1; req_pc = 16'h0014; rsp_ready = 1'b1; #1;
    check("t4_flush_ready", 64'(req_ready), 64'd1);
    check_rsp("t4_popped");
    push_exp(16'h0014, 32'hff5ff06f, 2'b00); tick();
    flush = 1'b0; req_valid = 1'b0;
    check_rsp("t4_after_flush"); tick();
    check("t4_drain", 64'(rsp_valid), 64'd0);

    // 5: loader priority, new data visible, out-of-range write
    ld_we = 1'b1; ld_addr = 7'd8; ld_data = 32'h005282b3;
    req_valid = 1'b1; req_pc = 16'h0020; #1;
    check("t5_load_blocks", 64'(req_ready), 64'd0);
    tick();
    ld_we = 1'b0; #1;
    check("t5_no_accept", 64'(rsp_valid), 64'd0);
    check("t5_ready_back", 64'(req_ready), 64'd1);
    push_exp(16'h0020, 32'h005282b3, 2'b00); tick();
    check_rsp("t5_new_data");
    req_valid = 1'b0;
    ld_we = 1'b1; ld_addr = 7'd64; ld_data = 32'hdeadbeef; #1;
    check("t5_err_idle", 64'(ld_err), 64'd0);
    tick();
    ld_we = 1'b0;
    check("t5_err_pulse", 64'(ld_err), 64'd1);
    tick();
    check("t5_err_clear", 64'(ld_err), 64'd0);
    req_valid = 1'b1; req_pc = 16'h0000;
    push_exp(16'h0000, 32'h00300413, 2'b00); tick();
    check_rsp("t5_mem0_intact");
    req_valid = 1'b0; tick();

    // 6: reset with responses pending, memory survives
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 16'h0020; tick();
    req_pc = 16'h0000; tick();
    req_valid = 1'b0;
    check("t6_pending", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_instr", 64'(rsp_instr), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_pc = 16'h0020;
    push_exp(16'h0020, 32'h005282b3, 2'b00); tick();
    check_rsp("t6_mem8");
    req_pc = 16'h0004;
    push_exp(16'h0004, 32'h00100493, 2'b00); tick();
    check_rsp("t6_mem1");
    req_valid = 1'b0; tick();
    check("t6_drain", 64'(rsp_valid), 64'd0);

    // Final report
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
